// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) / key-schedule helpers.
// S-boxes are computed arithmetically (field inverse plus affine map) instead of stored.
package aes_pkg;
  localparam int NK = 4;
  localparam int NR = 10;

  typedef logic [32*NK-1:0] block_t;
  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(gmul(a15, a15), gmul(a15, a15));
    a240 = gmul(gmul(a240, a240), gmul(a240, a240));
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic block_t key_fwd(input block_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot_word(w3) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one key-schedule step: recover round key r from round key r+1.
  function automatic block_t key_inv(input block_t k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, p3;
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    return {w0 ^ sub_rot_word(p3) ^ {rc, 24'h0}, w1 ^ w0, w2 ^ w1, p3};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_last,
  output logic [127:0] o_state
);
  logic [127:0] w_sb;
  logic [127:0] w_ark;
  logic [127:0] w_mc;

  genvar gi;
  // Byte index is row + 4*col; row r is rotated right by r columns.
  for (gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int SRC = ROW + 4 * (((gi / 4) - ROW + 4) % 4);
    assign w_sb[127-8*gi -: 8] = inv_sbox(i_state[127-8*SRC -: 8]);
  end

  assign w_ark = w_sb ^ i_round_key;

  for (gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign {w_a0, w_a1, w_a2, w_a3} = w_ark[127-32*gi -: 32];
    assign w_mc[127-32*gi -: 32] = {
      gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09),
      gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d),
      gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b),
      gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e)};
  end

  assign o_state = i_last ? w_ark : w_mc;
endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: walks the key forward to k10, then decrypts one
// round per clock while stepping the key schedule backwards to k0.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] decrypted_text,
  output logic         busy
);
  state_t       r_state;
  block_t       r_st;
  block_t       r_k;
  logic [3:0]   r_cnt;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic [127:0] r_dout;

  block_t w_k_fwd;
  block_t w_k_prev;
  block_t w_round_out;
  logic   w_last;

  // r_cnt is the round-constant index in KEXP and the round number in ROUND.
  assign w_k_fwd  = key_fwd(r_k, rcon(r_cnt));
  assign w_k_prev = key_inv(r_k, rcon(r_cnt + 4'd1));
  assign w_last   = (r_cnt == 4'd0);

  aes_inv_round u_round (
    .i_state     (r_st),
    .i_round_key (w_k_prev),
    .i_last      (w_last),
    .o_state     (w_round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_st        <= '0;
      r_k         <= '0;
      r_cnt       <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_dout      <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid && r_in_ready) begin
          r_st       <= cipher_text;
          r_k        <= key;
          r_cnt      <= 4'd1;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
          r_state    <= KEXP;
        end
        KEXP: begin
          r_k <= w_k_fwd;
          if (r_cnt == 4'(NR)) begin
            r_st    <= r_st ^ w_k_fwd;
            r_cnt   <= 4'(NR - 1);
            r_state <= ROUND;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ROUND: begin
          r_st <= w_round_out;
          r_k  <= w_k_prev;
          if (w_last) begin
            r_dout      <= w_round_out;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign busy           = r_busy;
  assign decrypted_text = r_dout;
endmodule
